// File: rtl/cls_stream_receiver.sv
// -----------------------------------------------------------------------------
// cls_stream_receiver
//
// SPI-slave receiver and decoder for the character-display command stream
// produced by the countdown controller. The expected frame is:
//     ESC '[' 'j' <tens digit> <ones digit> NUL
// Mode-0 SPI (MSB first) is deserialised into bytes. The parser turns the two
// ASCII digits back into a binary value and flags malformed frames. On the
// board this block is a display model, and in system benches it is a loopback
// checker.
//
// Parameters
//   SYNC_STAGES  synchroniser depth for sclk/mosi/ss (must be >= 2)
//   MAX_VALUE    largest decoded value accepted; larger values are errors
//   ERR_W        width of the saturating error counter
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous, active-high reset
//   sclk           in   SPI clock from master (async to clk, idles low)
//   mosi           in   SPI data, sampled on sclk rising edge
//   ss             in   slave select, active low (async)
//   rx_byte        out  last completed byte
//   rx_byte_valid  out  one-cycle strobe: rx_byte updated
//   value          out  last committed decoded value (tens*10 + ones)
//   value_valid    out  one-cycle strobe: value updated
//   clear_pulse    out  one-cycle strobe on an accepted ESC '[' 'j'
//   cmd_err        out  one-cycle strobe on any protocol or frame error
//   err_count      out  saturating count of cmd_err strobes
//   busy           out  high whenever the parser is not idle
// -----------------------------------------------------------------------------
module cls_stream_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_VALUE   = 63,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             ss,
    output logic [7:0]       rx_byte,
    output logic             rx_byte_valid,
    output logic [5:0]       value,
    output logic             value_valid,
    output logic             clear_pulse,
    output logic             cmd_err,
    output logic [ERR_W-1:0] err_count,
    output logic             busy
);

    localparam logic [7:0] CH_ESC  = 8'h1B;
    localparam logic [7:0] CH_BRKT = 8'h5B;
    localparam logic [7:0] CH_J    = 8'h6A;
    localparam logic [7:0] CH_NUL  = 8'h00;
    localparam logic [6:0] MAX_V   = MAX_VALUE[6:0];

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ESC,
        ST_BRKT,
        ST_DHI,
        ST_DLO,
        ST_WNUL
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronisers. Each chain is preset to the idle bus level (ss high,
    // sclk/mosi low), so leaving reset never looks like an edge.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic                   sclk_prev_q;
    logic                   ss_prev_q;

    logic sclk_s;
    logic mosi_s;
    logic ss_s;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];

    // NOTE: state is updated with non-blocking assignments, so every flop
    // samples the values from before the edge and the chains shift correctly.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

    // -------------------------------------------------------------------------
    // Edge detection and deserialiser
    // -------------------------------------------------------------------------
    logic       sclk_rise_d;
    logic       ss_rise_d;
    logic [2:0] bit_cnt_q;
    logic [2:0] bit_cnt_d;
    logic [6:0] shift_q;
    logic       byte_done_d;
    logic       abort_d;
    logic [7:0] rx_byte_q;
    logic       rx_byte_valid_q;

    // The edge is qualified by the previous-cycle ss. An 8th edge that lands
    // in the same cycle as the ss release still completes its byte.
    assign sclk_rise_d = sclk_s & ~sclk_prev_q & ~ss_prev_q;
    assign ss_rise_d   = ss_s & ~ss_prev_q;
    assign byte_done_d = sclk_rise_d && (bit_cnt_q == 3'd7);
    assign bit_cnt_d   = sclk_rise_d ? bit_cnt_q + 3'd1 : bit_cnt_q;

    // The abort test uses the count after this cycle's edge. A byte that
    // completes exactly as ss rises therefore leaves nothing to discard.
    assign abort_d = ss_rise_d && (bit_cnt_d != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q       <= 3'd0;
            shift_q         <= 7'd0;
            rx_byte_q       <= 8'd0;
            rx_byte_valid_q <= 1'b0;
        end else begin
            rx_byte_valid_q <= byte_done_d;
            bit_cnt_q       <= abort_d ? 3'd0 : bit_cnt_d;
            if (sclk_rise_d) begin
                shift_q <= {shift_q[5:0], mosi_s};
            end
            if (byte_done_d) begin
                rx_byte_q <= {shift_q, mosi_s};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame parser: next-state decode
    // -------------------------------------------------------------------------
    state_t     state_q;
    state_t     state_d;
    logic [3:0] tens_q;
    logic [3:0] tens_d;
    logic [3:0] ones_q;
    logic [3:0] ones_d;
    logic [5:0] value_q;
    logic [5:0] value_d;
    logic       value_valid_q;
    logic       value_valid_d;
    logic       clear_pulse_q;
    logic       clear_pulse_d;
    logic       parse_err_d;
    logic       cmd_err_q;
    logic       cmd_err_d;
    logic [ERR_W-1:0] err_count_q;
    logic       busy_q;
    logic       is_digit;
    logic [6:0] sum_d;

    assign is_digit = (rx_byte_q[7:4] == 4'h3) && (rx_byte_q[3:0] <= 4'd9);
    assign sum_d    = ({3'b000, tens_q} * 7'd10) + {3'b000, ones_q};

    // NOTE: every signal gets a default first, so no path through the case
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        tens_d        = tens_q;
        ones_d        = ones_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        clear_pulse_d = 1'b0;
        parse_err_d   = 1'b0;

        if (rx_byte_valid_q) begin
            case (state_q)
                ST_IDLE: begin
                    // Bytes outside a frame are ignored silently.
                    if (rx_byte_q == CH_ESC) begin
                        state_d = ST_ESC;
                    end
                end
                ST_ESC: begin
                    if (rx_byte_q == CH_BRKT) begin
                        state_d = ST_BRKT;
                    end else if (rx_byte_q != CH_ESC) begin
                        parse_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                ST_BRKT: begin
                    if (rx_byte_q == CH_J) begin
                        clear_pulse_d = 1'b1;
                        state_d       = ST_DHI;
                    end else begin
                        parse_err_d = 1'b1;
                        state_d     = (rx_byte_q == CH_ESC) ? ST_ESC : ST_IDLE;
                    end
                end
                ST_DHI: begin
                    if (is_digit) begin
                        tens_d  = rx_byte_q[3:0];
                        state_d = ST_DLO;
                    end else begin
                        parse_err_d = 1'b1;
                        state_d     = (rx_byte_q == CH_ESC) ? ST_ESC : ST_IDLE;
                    end
                end
                ST_DLO: begin
                    if (is_digit) begin
                        ones_d  = rx_byte_q[3:0];
                        state_d = ST_WNUL;
                    end else begin
                        parse_err_d = 1'b1;
                        state_d     = (rx_byte_q == CH_ESC) ? ST_ESC : ST_IDLE;
                    end
                end
                ST_WNUL: begin
                    if (rx_byte_q == CH_NUL) begin
                        state_d = ST_IDLE;
                        if (sum_d <= MAX_V) begin
                            value_d       = sum_d[5:0];
                            value_valid_d = 1'b1;
                        end else begin
                            parse_err_d = 1'b1;
                        end
                    end else begin
                        parse_err_d = 1'b1;
                        state_d     = (rx_byte_q == CH_ESC) ? ST_ESC : ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // An ss abort resynchronises the parser to the start of a frame.
        if (abort_d) begin
            state_d = ST_IDLE;
        end
    end

    // A parse error and an ss abort in the same cycle merge into one strobe.
    assign cmd_err_d = parse_err_d | abort_d;

    // -------------------------------------------------------------------------
    // Frame parser: state and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tens_q        <= 4'd0;
            ones_q        <= 4'd0;
            value_q       <= 6'd0;
            value_valid_q <= 1'b0;
            clear_pulse_q <= 1'b0;
            cmd_err_q     <= 1'b0;
            err_count_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tens_q        <= tens_d;
            ones_q        <= ones_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            clear_pulse_q <= clear_pulse_d;
            cmd_err_q     <= cmd_err_d;
            busy_q        <= (state_d != ST_IDLE);
            if (cmd_err_d && !(&err_count_q)) begin
                err_count_q <= err_count_q + ERR_W'(1);
            end
        end
    end

    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = rx_byte_valid_q;
    assign value         = value_q;
    assign value_valid   = value_valid_q;
    assign clear_pulse   = clear_pulse_q;
    assign cmd_err       = cmd_err_q;
    assign err_count     = err_count_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_cls_stream_receiver.sv
// -----------------------------------------------------------------------------
// Directed bench for cls_stream_receiver. It drives a mode-0 SPI master and
// counts the output strobes on the falling clk edge. Each step compares
// counter deltas and output values against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_cls_stream_receiver;

    localparam int HALF = 5;   // SPI half period in clk cycles (>= SYNC_STAGES+2)

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       ss   = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic [5:0] value;
    logic       value_valid;
    logic       clear_pulse;
    logic       cmd_err;
    logic [7:0] err_count;
    logic       busy;

    cls_stream_receiver #(
        .SYNC_STAGES(2),
        .MAX_VALUE  (63),
        .ERR_W      (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sclk         (sclk),
        .mosi         (mosi),
        .ss           (ss),
        .rx_byte      (rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .value        (value),
        .value_valid  (value_valid),
        .clear_pulse  (clear_pulse),
        .cmd_err      (cmd_err),
        .err_count    (err_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Strobe monitors
    int n_rxv  = 0;
    int n_clr  = 0;
    int n_vv   = 0;
    int n_err  = 0;
    int n_busy = 0;
    logic [7:0] rxq[$];

    always @(negedge clk) begin
        if (rx_byte_valid === 1'b1) begin
            n_rxv <= n_rxv + 1;
            rxq.push_back(rx_byte);
        end
        if (clear_pulse === 1'b1) n_clr  <= n_clr + 1;
        if (value_valid === 1'b1) n_vv   <= n_vv + 1;
        if (cmd_err === 1'b1)     n_err  <= n_err + 1;
        if (busy === 1'b1)        n_busy <= n_busy + 1;
    end

    int b_rxv, b_clr, b_vv, b_err, b_busy;
    logic [7:0] frame[$];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic snap();
        b_rxv  = n_rxv;
        b_clr  = n_clr;
        b_vv   = n_vv;
        b_err  = n_err;
        b_busy = n_busy;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b);
        mosi = b;
        tick(HALF);
        sclk = 1'b1;
        tick(HALF);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic send_frame();
        ss = 1'b0;
        tick(4);
        foreach (frame[k]) spi_byte(frame[k]);
        tick(4);
        ss = 1'b1;
        tick(12);
    endtask

    // Partial byte followed by an ss release: a single abort error.
    task automatic abort_after(input int nbits);
        ss = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) spi_bit(1'b1);
        tick(2);
        ss = 1'b1;
        tick(8);
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick(5);
        check("reset_rx_byte",     rx_byte, 0);
        check("reset_rx_valid",    rx_byte_valid, 0);
        check("reset_value",       value, 0);
        check("reset_value_valid", value_valid, 0);
        check("reset_clear",       clear_pulse, 0);
        check("reset_cmd_err",     cmd_err, 0);
        check("reset_err_count",   err_count, 0);
        check("reset_busy",        busy, 0);
        rst = 1'b0;
        tick(5);

        // ---------------- clean frame 42 ----------------
        rxq.delete();
        snap();
        frame = {8'h1B, 8'h5B, 8'h6A};
        send_frame();
        check("t1_clear_after_j", n_clr - b_clr, 1);
        check("t1_no_value_yet",  n_vv - b_vv, 0);
        check("t1_busy_mid",      busy, 1);
        frame = {8'h34, 8'h32, 8'h00};
        send_frame();
        check("t1_clear_total",   n_clr - b_clr, 1);
        check("t1_value_valid",   n_vv - b_vv, 1);
        check("t1_value",         value, 42);
        check("t1_no_err",        n_err - b_err, 0);
        check("t1_rx_strobes",    n_rxv - b_rxv, 6);
        check("t1_rxq_size",      rxq.size(), 6);
        if (rxq.size() == 6) begin
            check("t1_rx0", rxq[0], 8'h1B);
            check("t1_rx1", rxq[1], 8'h5B);
            check("t1_rx2", rxq[2], 8'h6A);
            check("t1_rx3", rxq[3], 8'h34);
            check("t1_rx4", rxq[4], 8'h32);
            check("t1_rx5", rxq[5], 8'h00);
        end
        check("t1_busy_end",      busy, 0);

        // ---------------- 64 > MAX_VALUE, then 00 ----------------
        snap();
        frame = {8'h1B, 8'h5B, 8'h6A, 8'h36, 8'h34, 8'h00};
        send_frame();
        check("t2_err_once",      n_err - b_err, 1);
        check("t2_err_count",     err_count, 1);
        check("t2_value_kept",    value, 42);
        check("t2_no_valid",      n_vv - b_vv, 0);
        snap();
        frame = {8'h1B, 8'h5B, 8'h6A, 8'h30, 8'h30, 8'h00};
        send_frame();
        check("t2_zero_value",    value, 0);
        check("t2_zero_valid",    n_vv - b_vv, 1);
        check("t2_zero_no_err",   n_err - b_err, 0);

        // ---------------- restart inside a frame ----------------
        snap();
        frame = {8'h1B, 8'h5B, 8'h6A, 8'h33, 8'h1B, 8'h5B, 8'h6A, 8'h31, 8'h35, 8'h00};
        send_frame();
        check("t3_err_once",      n_err - b_err, 1);
        check("t3_two_clears",    n_clr - b_clr, 2);
        check("t3_value",         value, 15);
        check("t3_valid",         n_vv - b_vv, 1);
        check("t3_err_count",     err_count, 2);

        // ---------------- ss abort after 5 bits ----------------
        snap();
        abort_after(5);
        check("t4_abort_err",     n_err - b_err, 1);
        check("t4_abort_no_byte", n_rxv - b_rxv, 0);
        check("t4_err_count",     err_count, 3);
        check("t4_busy",          busy, 0);
        frame = {8'h1B, 8'h5B, 8'h6A, 8'h30, 8'h37, 8'h00};
        send_frame();
        check("t4_value",         value, 7);
        check("t4_valid",         n_vv - b_vv, 1);
        check("t4_no_more_err",   n_err - b_err, 1);
        check("t4_rx_aligned",    n_rxv - b_rxv, 6);

        // ---------------- stray bytes, double ESC, 99 ----------------
        snap();
        frame = {8'h41, 8'h00};
        send_frame();
        check("t5_stray_no_err",  n_err - b_err, 0);
        check("t5_stray_no_busy", n_busy - b_busy, 0);
        check("t5_stray_bytes",   n_rxv - b_rxv, 2);
        snap();
        frame = {8'h1B, 8'h1B, 8'h5B, 8'h6A, 8'h39, 8'h39};
        send_frame();
        check("t5_dbl_esc_no_err", n_err - b_err, 0);
        check("t5_dbl_esc_clear",  n_clr - b_clr, 1);
        frame = {8'h00};
        send_frame();
        check("t5_99_err",        n_err - b_err, 1);
        check("t5_99_value_kept", value, 7);
        check("t5_99_no_valid",   n_vv - b_vv, 0);
        check("t5_err_count",     err_count, 4);

        // ---------------- counter saturation ----------------
        snap();
        for (int i = 0; i < 251; i++) abort_after(1);
        check("t6_err_count_255", err_count, 255);
        for (int i = 0; i < 49; i++) abort_after(1);
        check("t6_err_count_sat", err_count, 255);
        check("t6_strobes",       n_err - b_err, 300);

        // ---------------- reset mid-frame ----------------
        ss = 1'b0;
        tick(4);
        spi_byte(8'h1B);
        spi_byte(8'h5B);
        for (int i = 0; i < 4; i++) spi_bit(1'b1);
        check("t7_busy_before",   busy, 1);
        snap();
        rst = 1'b1;
        tick(3);
        check("t7_rst_value",     value, 0);
        check("t7_rst_err_count", err_count, 0);
        check("t7_rst_busy",      busy, 0);
        check("t7_rst_rx_byte",   rx_byte, 0);
        check("t7_rst_cmd_err",   cmd_err, 0);
        ss = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(12);
        check("t7_no_err_strobe", n_err - b_err, 0);
        check("t7_busy_after",    busy, 0);
        check("t7_err_count_0",   err_count, 0);
        frame = {8'h1B, 8'h5B, 8'h6A, 8'h34, 8'h32, 8'h00};
        send_frame();
        check("t7_value",         value, 42);
        check("t7_clean_no_err",  n_err - b_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
